// File: rtl/logic_slice_sequencer.sv
// ---------------------------------------------------------------------------
// logic_slice_sequencer
//
// Multi-cycle bitwise logic unit (AND / OR / XOR / NOR). A single SLICE_W-bit
// logic slice is reused over DATA_W/SLICE_W consecutive cycles, one slice of
// the latched operands per cycle, and the result is assembled in place.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-high reset
//   start   in   operation request, sampled only while idle
//   op      in   [1:0] 00 AND, 01 OR, 10 XOR, 11 NOR
//   a, b    in   [DATA_W-1:0] operands, latched when start is accepted
//   busy    out  high while an operation is running or completing
//   done    out  one-cycle pulse, result and zero valid
//   result  out  [DATA_W-1:0] assembled result, held until next start
//   zero    out  result == 0, updated together with done
// ---------------------------------------------------------------------------
module logic_slice_sequencer #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [IDX_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [1:0]          r_op;
    logic [DATA_W-1:0]   r_result;
    logic                r_zero;

    logic                w_accept;
    logic                w_last;
    logic [SLICE_W-1:0]  w_a_slice;
    logic [SLICE_W-1:0]  w_b_slice;
    logic [SLICE_W-1:0]  w_slice_out;
    logic [DATA_W-1:0]   w_result_next;
    logic [SLICE_W-1:0]  w_a_arr [NSLICE];
    logic [SLICE_W-1:0]  w_b_arr [NSLICE];

    // Operand slices as arrays so the current slice is a simple index mux,
    // and the result image with only the current slice replaced.
    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign w_a_arr[gi] = r_a[gi*SLICE_W +: SLICE_W];
            assign w_b_arr[gi] = r_b[gi*SLICE_W +: SLICE_W];
            assign w_result_next[gi*SLICE_W +: SLICE_W] =
                (r_idx == IDX_W'(gi)) ? w_slice_out
                                      : r_result[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign w_a_slice = w_a_arr[r_idx];
    assign w_b_slice = w_b_arr[r_idx];
    assign w_last    = (r_idx == LAST_IDX);

    // The shared logic slice
    always_comb begin
        w_slice_out = '0;
        case (r_op)
            2'b00:   w_slice_out = w_a_slice & w_b_slice;
            2'b01:   w_slice_out = w_a_slice | w_b_slice;
            2'b10:   w_slice_out = w_a_slice ^ w_b_slice;
            default: w_slice_out = ~(w_a_slice | w_b_slice);
        endcase
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_op     <= op;
                r_result <= '0;
                r_idx    <= '0;
            end else if (r_state == S_RUN) begin
                r_result <= w_result_next;
                r_idx    <= w_last ? '0 : r_idx + IDX_W'(1);
                // The flag is computed from the fully assembled image on the
                // last slice so it is already valid while done is high.
                if (w_last) begin
                    r_zero <= (w_result_next == '0);
                end
            end
        end
    end

    assign result = r_result;
    assign zero   = r_zero;

endmodule

// File: tb/tb_logic_slice_sequencer.sv
module tb_logic_slice_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;

    int n_pass  = 0;
    int n_total = 0;
    logic exp_zero = 1'b0;   // zero flag the model expects right now

    always #5 clk = ~clk;

    logic_slice_sequencer #(.DATA_W(32), .SLICE_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero)
    );

    function automatic logic [31:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic [1:0] o);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    // Issue one operation and observe it over a bounded 12-cycle window.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic [1:0] top,
                         output logic [31:0] res, output logic z, output int lat,
                         output int ndone, output logic busy_ok, output logic busy_after,
                         output logic [31:0] res1, output logic z_run);
        @(negedge clk);
        a = ta; b = tb_; op = top; start = 1'b1;
        @(negedge clk);                 // edge T has been taken
        start = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        lat = -1; ndone = 0; busy_ok = busy; busy_after = 1'b1;
        res = '0; z = 1'b0; res1 = '0; z_run = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin res1 = result; z_run = zero; end
            if (done) begin
                ndone++;
                if (lat < 0) begin lat = k; res = result; z = zero; end
            end else if (lat < 0 && !busy) begin
                busy_ok = 1'b0;
            end
            if (lat > 0 && k == lat + 1) busy_after = busy;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom;
            @(negedge clk);
            n_total++; if (busy !== 1'b0) $display("FAIL reset_busy cyc%0d got %b exp 0", i, busy); else n_pass++;
            n_total++; if (done !== 1'b0) $display("FAIL reset_done cyc%0d got %b exp 0", i, done); else n_pass++;
            n_total++; if (result !== 32'h0) $display("FAIL reset_result cyc%0d got %h exp 0", i, result); else n_pass++;
            n_total++; if (zero !== 1'b0) $display("FAIL reset_zero cyc%0d got %b exp 0", i, zero); else n_pass++;
        end
        $display("test_reset: idle after reset checked for 5 cycles");
        exp_zero = 1'b0;
    endtask

    task automatic test_and_timing;
        logic [31:0] res, res1; logic z, bo, ba, zr; int lat, nd;
        do_op(32'hFFFF0000, 32'h0F0F0F0F, 2'b00, res, z, lat, nd, bo, ba, res1, zr);
        $display("AND a=ffff0000 b=0f0f0f0f -> %h z=%b lat=%0d", res, z, lat);
        n_total++; if (lat !== 8) $display("FAIL and_latency got %0d exp 8", lat); else n_pass++;
        n_total++; if (nd !== 1) $display("FAIL and_done_count got %0d exp 1", nd); else n_pass++;
        n_total++; if (res !== 32'h0F0F0000) $display("FAIL and_result got %h exp 0f0f0000", res); else n_pass++;
        n_total++; if (z !== 1'b0) $display("FAIL and_zero got %b exp 0", z); else n_pass++;
        n_total++; if (bo !== 1'b1) $display("FAIL and_busy_run got %b exp 1", bo); else n_pass++;
        n_total++; if (ba !== 1'b0) $display("FAIL and_busy_after got %b exp 0", ba); else n_pass++;
        n_total++; if (res1 !== 32'h0) $display("FAIL and_partial got %h exp 00000000", res1); else n_pass++;
        exp_zero = 1'b0;
    endtask

    task automatic test_sweep;
        logic [31:0] res, res1; logic z, bo, ba, zr; int lat, nd;
        logic [31:0] exp_r [4];
        logic [31:0] ta [4];
        logic [31:0] tbv [4];
        logic [1:0]  to [4];
        ta[0] = 32'hFFFF0000; tbv[0] = 32'h0F0F0F0F; to[0] = 2'b01; exp_r[0] = 32'hFFFF0F0F;
        ta[1] = 32'hFFFF0000; tbv[1] = 32'h0F0F0F0F; to[1] = 2'b10; exp_r[1] = 32'hF0F00F0F;
        ta[2] = 32'hFFFF0000; tbv[2] = 32'h0F0F0F0F; to[2] = 2'b11; exp_r[2] = 32'h0000F0F0;
        ta[3] = 32'h00000000; tbv[3] = 32'h00000000; to[3] = 2'b11; exp_r[3] = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tbv[i], to[i], res, z, lat, nd, bo, ba, res1, zr);
            $display("sweep op=%0d a=%h b=%h -> %h z=%b", to[i], ta[i], tbv[i], res, z);
            n_total++; if (res !== exp_r[i]) $display("FAIL sweep_result op%0d got %h exp %h", to[i], res, exp_r[i]); else n_pass++;
            n_total++; if (lat !== 8 || nd !== 1) $display("FAIL sweep_timing op%0d lat %0d nd %0d exp 8/1", to[i], lat, nd); else n_pass++;
            n_total++; if (res1 !== (exp_r[i] & 32'hF)) $display("FAIL sweep_partial op%0d got %h exp %h", to[i], res1, exp_r[i] & 32'hF); else n_pass++;
        end
        exp_zero = 1'b0;
    endtask

    task automatic test_zero_flag;
        logic [31:0] res, res1; logic z, bo, ba, zr; int lat, nd;
        do_op(32'hAAAAAAAA, 32'h55555555, 2'b00, res, z, lat, nd, bo, ba, res1, zr);
        $display("zero1 AND aaaaaaaa/55555555 -> %h z=%b", res, z);
        n_total++; if (res !== 32'h0) $display("FAIL zero1_result got %h exp 00000000", res); else n_pass++;
        n_total++; if (z !== 1'b1) $display("FAIL zero1_flag got %b exp 1", z); else n_pass++;
        do_op(32'h1, 32'h1, 2'b00, res, z, lat, nd, bo, ba, res1, zr);
        $display("zero2 AND 1/1 -> %h z=%b zrun=%b", res, z, zr);
        n_total++; if (zr !== 1'b1) $display("FAIL zero2_held_in_run got %b exp 1", zr); else n_pass++;
        n_total++; if (res !== 32'h1) $display("FAIL zero2_result got %h exp 00000001", res); else n_pass++;
        n_total++; if (z !== 1'b0) $display("FAIL zero2_flag got %b exp 0", z); else n_pass++;
        exp_zero = 1'b0;
    endtask

    task automatic test_busy_protect;
        int nd = 0; int lat = -1; logic [31:0] res = '0; logic b_idle;
        @(negedge clk);
        a = 32'hFFFF0000; b = 32'h0F0F0F0F; op = 2'b10; start = 1'b1;
        @(negedge clk);
        a = '0; b = '0; op = 2'b01;            // start stays high
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (done) begin nd++; if (lat < 0) begin lat = k; res = result; end end
        end
        b_idle = busy;                          // IDLE cycle, start still high
        $display("busy_protect XOR -> %h done_count=%0d lat=%0d", res, nd, lat);
        n_total++; if (nd !== 1) $display("FAIL busy_done_count got %0d exp 1", nd); else n_pass++;
        n_total++; if (res !== 32'hF0F00F0F) $display("FAIL busy_result got %h exp f0f00f0f", res); else n_pass++;
        n_total++; if (lat !== 8) $display("FAIL busy_latency got %0d exp 8", lat); else n_pass++;
        n_total++; if (b_idle !== 1'b0) $display("FAIL busy_idle_gap got %b exp 0", b_idle); else n_pass++;
        @(negedge clk);                         // new op accepted from IDLE
        start = 1'b0;
        n_total++; if (busy !== 1'b1) $display("FAIL busy_second_accept got %b exp 1", busy); else n_pass++;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done && lat < 0) begin lat = k; res = result; end
        end
        $display("busy_protect second OR 0/0 -> %h lat=%0d", res, lat);
        n_total++; if (lat !== 8 || res !== 32'h0) $display("FAIL busy_second_op lat %0d res %h exp 8/00000000", lat, res); else n_pass++;
        exp_zero = 1'b1;
    endtask

    task automatic test_reset_mid;
        int nd = 0;
        logic [31:0] res, res1; logic z, bo, ba, zr; int lat, ndd;
        @(negedge clk);
        a = 32'h12345678; b = 32'h0F0F0F0F; op = 2'b01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;                           // RUN cycle 4
        @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else n_pass++;
        n_total++; if (result !== 32'h0) $display("FAIL rmid_result got %h exp 0", result); else n_pass++;
        n_total++; if (zero !== 1'b0) $display("FAIL rmid_zero got %b exp 0", zero); else n_pass++;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        n_total++; if (nd !== 0) $display("FAIL rmid_no_done got %0d exp 0", nd); else n_pass++;
        exp_zero = 1'b0;
        do_op(32'h12345678, 32'h0F0F0F0F, 2'b01, res, z, lat, ndd, bo, ba, res1, zr);
        $display("reset_mid then OR -> %h lat=%0d", res, lat);
        n_total++; if (zr !== 1'b0) $display("FAIL rmid_zero_run got %b exp 0", zr); else n_pass++;
        n_total++; if (res !== 32'h1F3F5F7F || lat !== 8) $display("FAIL rmid_after res %h lat %0d exp 1f3f5f7f/8", res, lat); else n_pass++;
    endtask

    task automatic test_random;
        logic [31:0] res, res1, ra, rb, er; logic z, bo, ba, zr; int lat, nd; logic [1:0] ro;
        for (int i = 0; i < 20; i++) begin
            ra = $urandom; rb = $urandom; ro = 2'($urandom);
            if (i % 5 == 0) rb = ~ra;            // steer some ops toward zero
            er = ref_op(ra, rb, ro);
            do_op(ra, rb, ro, res, z, lat, nd, bo, ba, res1, zr);
            $display("rand%0d op=%0d a=%h b=%h -> %h exp %h z=%b", i, ro, ra, rb, res, er, z);
            n_total++; if (res !== er) $display("FAIL rand_result #%0d got %h exp %h", i, res, er); else n_pass++;
            n_total++; if (z !== (er == 32'h0)) $display("FAIL rand_zero #%0d got %b exp %b", i, z, er == 32'h0); else n_pass++;
            n_total++; if (zr !== exp_zero) $display("FAIL rand_zero_held #%0d got %b exp %b", i, zr, exp_zero); else n_pass++;
            n_total++; if (res1 !== (er & 32'hF)) $display("FAIL rand_partial #%0d got %h exp %h", i, res1, er & 32'hF); else n_pass++;
            n_total++; if (lat !== 8 || nd !== 1 || bo !== 1'b1 || ba !== 1'b0)
                $display("FAIL rand_timing #%0d lat %0d nd %0d busy %b/%b exp 8 1 1/0", i, lat, nd, bo, ba); else n_pass++;
            exp_zero = (er == 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_and_timing();
        test_sweep();
        test_zero_flag();
        test_busy_protect();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
